// File: rtl/spin_round_ctrl.sv
// rtl/spin_round_ctrl.sv - slot-machine round sequencer: debit, spin, timed reel stops, win evaluation, payout
// Optional build macro SPIN_EARLY_STOP_EN: a start press while reels run cuts the current phase short.
module spin_round_ctrl #(
    parameter int             TW       = 27,
    parameter logic [TW-1:0]  SPIN_CYC = 27'd100_000_000,
    parameter logic [TW-1:0]  GAP_CYC  = 27'd25_000_000,
    parameter logic [11:0]    BET      = 12'h015,
    parameter logic [11:0]    PAY3     = 12'h100,
    parameter logic [11:0]    PAY2     = 12'h020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] coin,
    output logic        debit_req,
    input  logic        debit_ack,
    output logic [2:0]  reel_run,
    input  logic [3:0]  sym0,
    input  logic [3:0]  sym1,
    input  logic [3:0]  sym2,
    output logic        payout_valid,
    output logic [11:0] payout,
    input  logic        payout_ack,
    output logic        no_credit,
    output logic        busy,
    output logic        finish
);

    typedef enum logic [3:0] {
        IDLE, DEBIT, SPIN, STOP0, STOP1, STOP2, EVAL, PAY, DONE
    } state_t;

    localparam logic [TW-1:0] ONE = {{(TW-1){1'b0}}, 1'b1};

    state_t        state;
    logic [TW-1:0] timer;
    logic          start_q;
    logic [3:0]    lsym0, lsym1, lsym2;

    logic          start_rise;
    logic          early_stop;
    logic          credit_ok;
    logic [11:0]   eval_pay;
    logic [TW-1:0] next_timer;

    // Packed BCD keeps numeric order, so a binary compare is a valid credit check.
    assign credit_ok  = (coin >= BET);
    assign start_rise = start & ~start_q;

`ifdef SPIN_EARLY_STOP_EN
    assign early_stop = start_rise;
`else
    assign early_stop = 1'b0;
`endif

    // Only used while timer is non-zero, so the decrement cannot wrap.
    assign next_timer = early_stop ? '0 : timer - ONE;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    always_comb begin
        eval_pay = '0;
        if (lsym0 == lsym1 && lsym1 == lsym2)
            eval_pay = PAY3;
        else if (lsym0 == lsym1)
            eval_pay = PAY2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            start_q      <= 1'b0;
            lsym0        <= '0;
            lsym1        <= '0;
            lsym2        <= '0;
            debit_req    <= 1'b0;
            reel_run     <= 3'b000;
            payout_valid <= 1'b0;
            payout       <= '0;
            no_credit    <= 1'b0;
            busy         <= 1'b0;
            finish       <= 1'b0;
        end else begin
            start_q   <= start;
            no_credit <= 1'b0;
            finish    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        if (credit_ok) begin
                            state     <= DEBIT;
                            debit_req <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            no_credit <= 1'b1;
                        end
                    end
                end
                DEBIT: begin
                    if (debit_ack) begin
                        debit_req <= 1'b0;
                        reel_run  <= 3'b111;
                        timer     <= sat_dec(SPIN_CYC);
                        state     <= SPIN;
                    end
                end
                SPIN: begin
                    if (timer == '0) begin
                        reel_run[0] <= 1'b0;
                        lsym0       <= sym0;
                        timer       <= sat_dec(GAP_CYC);
                        state       <= STOP0;
                    end else begin
                        timer <= next_timer;
                    end
                end
                STOP0: begin
                    if (timer == '0) begin
                        reel_run[1] <= 1'b0;
                        lsym1       <= sym1;
                        timer       <= sat_dec(GAP_CYC);
                        state       <= STOP1;
                    end else begin
                        timer <= next_timer;
                    end
                end
                STOP1: begin
                    if (timer == '0) begin
                        reel_run[2] <= 1'b0;
                        lsym2       <= sym2;
                        state       <= STOP2;
                    end else begin
                        timer <= next_timer;
                    end
                end
                STOP2: state <= EVAL;
                EVAL: begin
                    payout <= eval_pay;
                    if (eval_pay != '0) begin
                        payout_valid <= 1'b1;
                        state        <= PAY;
                    end else begin
                        finish <= 1'b1;
                        state  <= DONE;
                    end
                end
                PAY: begin
                    if (payout_ack) begin
                        payout_valid <= 1'b0;
                        finish       <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    debit_req    <= 1'b0;
                    payout_valid <= 1'b0;
                    reel_run     <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spin_round_ctrl.sv
// tb/tb_spin_round_ctrl.sv - scoreboard bench for spin_round_ctrl with a decimal-arithmetic reference model
module tb_spin_round_ctrl;

    localparam int SPIN = 10;
    localparam int GAP  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] coin;
    logic        debit_req;
    logic        debit_ack;
    logic [2:0]  reel_run;
    logic [3:0]  sym0, sym1, sym2;
    logic        payout_valid;
    logic [11:0] payout;
    logic        payout_ack;
    logic        no_credit;
    logic        busy;
    logic        finish;

    spin_round_ctrl #(
        .TW(27), .SPIN_CYC(27'd10), .GAP_CYC(27'd4),
        .BET(12'h015), .PAY3(12'h100), .PAY2(12'h020)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .coin(coin),
        .debit_req(debit_req), .debit_ack(debit_ack), .reel_run(reel_run),
        .sym0(sym0), .sym1(sym1), .sym2(sym2),
        .payout_valid(payout_valid), .payout(payout), .payout_ack(payout_ack),
        .no_credit(no_credit), .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [11:0] amt;
    } ev_t;

    ev_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    endtask

    function automatic int bcd_val(input logic [11:0] c);
        return int'(c[11:8]) * 100 + int'(c[7:4]) * 10 + int'(c[3:0]);
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic int win_amount(input int a, input int b, input int c);
        if (a == b && b == c) return 100;
        if (a == b) return 20;
        return 0;
    endfunction

    task automatic expect_ev(input int k, input logic [11:0] amt);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: actual kind %0d required none", k);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            if (k == 1) chk("payout_amount", amt, e.amt);
        end
    endtask

    // Kinds: 0 no_credit pulse, 1 accepted payout, 2 finish pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (no_credit)                 expect_ev(0, 12'h000);
            if (payout_valid && payout_ack) expect_ev(1, payout);
            if (finish)                    expect_ev(2, 12'h000);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            payout_ack = payout_valid;
            tick();
            if (!busy) done = 1;
        end
        payout_ack = 1'b0;
        chk("round_ends", busy, 1'b0);
    endtask

    task automatic play_round(input logic [11:0] c, input logic [3:0] s0, input logic [3:0] s1,
                              input logic [3:0] s2, input int ack_dly, input int pay_dly,
                              input bit abort_stop1, input bit early_poke);
        int          win;
        logic [11:0] exp_pay;
        coin = c; sym0 = s0; sym1 = s1; sym2 = s2;
        win = win_amount(int'(s0), int'(s1), int'(s2));
        exp_pay = to_bcd(win);
        if (bcd_val(c) < 15) begin
            exp_q.push_back('{kind: 0, amt: 12'h000});
            start = 1'b1; tick(); start = 1'b0;
            chk("lowcred_debit", debit_req, 1'b0);
            chk("lowcred_busy", busy, 1'b0);
            tick();
            chk("lowcred_busy2", busy, 1'b0);
            return;
        end
        if (!abort_stop1) begin
            if (win != 0) exp_q.push_back('{kind: 1, amt: exp_pay});
            exp_q.push_back('{kind: 2, amt: 12'h000});
        end
        start = 1'b1; tick(); start = 1'b0;
        chk("debit_req_rise", debit_req, 1'b1);
        chk("busy_rise", busy, 1'b1);
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            chk("debit_req_hold", debit_req, 1'b1);
        end
        debit_ack = 1'b1; tick(); debit_ack = 1'b0;
        chk("reels_start", reel_run, 3'b111);
        chk("debit_req_drop", debit_req, 1'b0);
        if (early_poke) begin
            repeat (3) tick();
            start = 1'b1; tick(); start = 1'b0;
            tick();
`ifdef SPIN_EARLY_STOP_EN
            chk("early_stop", reel_run, 3'b110);
`else
            chk("early_ignored", reel_run, 3'b111);
`endif
            wait_idle();
            return;
        end
        repeat (SPIN - 1) tick();
        chk("spin_len", reel_run, 3'b111);
        tick();
        chk("stop0", reel_run, 3'b110);
        sym0 = 4'($urandom);
        repeat (GAP - 1) tick();
        chk("gap0_len", reel_run, 3'b110);
        tick();
        chk("stop1", reel_run, 3'b100);
        if (abort_stop1) begin
            rst = 1'b1; tick(); rst = 1'b0;
            chk("abort_reels", reel_run, 3'b000);
            chk("abort_outs", {debit_req, payout_valid, payout, no_credit, busy, finish}, '0);
            for (int i = 0; i < 30; i++) begin
                tick();
                if (debit_req || payout_valid || busy) begin
                    chk("abort_quiet", {debit_req, payout_valid, busy}, 3'b000);
                    break;
                end
            end
            return;
        end
        sym1 = 4'($urandom);
        repeat (GAP - 1) tick();
        chk("gap1_len", reel_run, 3'b100);
        tick();
        chk("stop2", reel_run, 3'b000);
        sym2 = 4'($urandom);
        tick();
        tick();
        if (win != 0) begin
            chk("payout_valid_rise", payout_valid, 1'b1);
            for (int i = 0; i < pay_dly; i++) begin
                tick();
                chk("payout_hold", {payout_valid, payout}, {1'b1, exp_pay});
            end
            payout_ack = 1'b1; tick(); payout_ack = 1'b0;
            chk("payout_valid_drop", payout_valid, 1'b0);
        end else begin
            chk("no_payout", payout_valid, 1'b0);
        end
        chk("finish_pulse", finish, 1'b1);
        tick();
        chk("idle_after", {busy, finish}, 2'b00);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; coin = '0; debit_ack = 1'b0; payout_ack = 1'b0;
        sym0 = '0; sym1 = '0; sym2 = '0;
        tick(); tick();
        chk("reset_outs", {debit_req, reel_run, payout_valid, payout, no_credit, busy, finish}, '0);
        rst = 1'b0;
        tick();

        play_round(12'h010, 4'd1, 4'd2, 4'd3, 0, 0, 0, 0);
        play_round(12'h025, 4'd1, 4'd2, 4'd3, 3, 0, 0, 0);
        play_round(12'h025, 4'd7, 4'd7, 4'd7, 1, 3, 0, 0);
        play_round(12'h025, 4'd5, 4'd5, 4'd2, 0, 0, 0, 0);
        play_round(12'h015, 4'd3, 4'd3, 4'd3, 2, 1, 1, 0);
        play_round(12'h015, 4'd9, 4'd9, 4'd9, 0, 2, 0, 0);
        play_round(12'h099, 4'd2, 4'd2, 4'd2, 1, 0, 0, 1);
        play_round(12'h014, 4'd2, 4'd2, 4'd2, 0, 0, 0, 0);

        for (int r = 0; r < 25; r++) begin
            logic [11:0] c;
            c = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            play_round(c, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)),
                       $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spin_round_ctrl.md
Name: spin_round_ctrl

Overview:
- Sequences one slot-machine game round around the BCD credit counter.
- Checks credit, requests the bet debit, spins and stops the three reels at timed intervals, and latches the stopped symbols.
- Evaluates the win and hands the payout back to the credit counter, then pulses `finish` to release the counter's play lock.
- Sits between the debounced play button, the credit counter and the three reel drivers.

Parameters:
- TW, 27: width of the internal cycle timer.
- SPIN_CYC, 27'd100_000_000: cycles all reels spin before reel 0 stops.
- GAP_CYC, 27'd25_000_000: cycles between successive reel stops.
- BET, 12'h015: packed-BCD bet (hundreds/tens/ones).
- PAY3, 12'h100: packed-BCD payout when all three symbols are equal.
- PAY2, 12'h020: packed-BCD payout when only sym0 == sym1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: debounced play button, level; rising edge detected internally.
- coin, input, 12: current credit, packed BCD.
- debit_req, output, 1: request to subtract BET from credit.
- debit_ack, input, 1: credit counter accepted the debit.
- reel_run, output, 3: bit i high means reel i spins.
- sym0, input, 4: live symbol of reel 0.
- sym1, input, 4: live symbol of reel 1.
- sym2, input, 4: live symbol of reel 2.
- payout_valid, output, 1: payout amount offered to the credit counter.
- payout, output, 12: packed-BCD win amount.
- payout_ack, input, 1: credit counter accepted the payout.
- no_credit, output, 1: 1-cycle pulse when start is rejected for insufficient credit.
- busy, output, 1: high in every state except IDLE.
- finish, output, 1: 1-cycle pulse at round end.

Behaviour:
- Reset values (synchronous, rst high at a clk edge): state IDLE, timer 0, start-edge register 0, latched symbols 0. All outputs 0: debit_req, reel_run=3'b000, payout_valid, payout=12'h000, no_credit, busy, finish. rst mid-round aborts immediately with no debit or payout issued afterwards.
- Credit check: `coin >= BET` is a plain 12-bit unsigned compare, valid because packed BCD is order-preserving.
- Start edge: `start_rise = start & ~start_q`, evaluated only in IDLE. Edges in all other states are ignored.
- IDLE:
  - start_rise with enough credit -> DEBIT, with debit_req=1 the next cycle.
  - start_rise without enough credit -> no_credit=1 for one cycle; stay in IDLE.
- DEBIT:
  - debit_req stays high until debit_ack is sampled high.
  - The next cycle: debit_req=0, reel_run=3'b111, timer=SPIN_CYC-1, state SPIN.
  - debit_ack outside DEBIT is ignored.
- SPIN: timer decrements each cycle. At timer==0 -> STOP0; SPIN lasts exactly SPIN_CYC cycles.
- STOP0 entry cycle: reel_run[0]=0, sym0 latched, timer=GAP_CYC-1. Timer expiry -> STOP1.
- STOP1: same as STOP0 for reel 1 / sym1. Timer expiry -> STOP2.
- STOP2: reel_run[2]=0 and sym2 latched on entry, then -> EVAL the following cycle.
- EVAL (one cycle):
  - All three latched symbols equal -> payout=PAY3.
  - Else lsym0==lsym1 -> payout=PAY2.
  - Else payout=0.
  - Non-zero payout -> PAY; zero payout -> DONE.
- PAY:
  - payout_valid=1 with payout held stable until payout_ack is sampled high.
  - The next cycle: payout_valid=0, state DONE.
  - payout keeps its value until the next EVAL.
- DONE: finish=1 for exactly one cycle, then IDLE.
- Handshake rule: a request and its ack in the same cycle completes the transfer; the request drops the following cycle.
- Timer saturation: the timer never wraps below 0. A GAP_CYC or SPIN_CYC value of 1 gives single-cycle phases.

Optional Feature:
- Macro: SPIN_EARLY_STOP_EN.
- Defined: a start_rise during SPIN, STOP0 or STOP1 forces the current timer to 0, so the next reel stops on the following cycle. Edges in other states are still ignored.
- Undefined: start is ignored outside IDLE; phase lengths are fixed by the parameters.

Test Plan:
- Setup for all scenarios: SPIN_CYC=10, GAP_CYC=4.
- Low credit: coin=12'h010, start rise -> no_credit pulses 1 cycle, debit_req stays 0, busy stays 0.
- Full round, no win: coin=12'h025, start rise; debit_ack given 3 cycles after debit_req; syms 1,2,3.
  - reel_run=111 the cycle after the ack.
  - reel_run bit 0 clears 10 cycles later, bit 1 4 cycles after that, bit 2 4 cycles after that.
  - payout_valid never asserts; finish pulses once; busy falls.
- Three-of-a-kind: syms all 4'd7 at stop time -> payout_valid=1 with payout=12'h100 held until payout_ack, then finish.
- Pair only: syms 5,5,2 -> payout=12'h020. Also check that symbols changing after their reel stops do not alter the result.
- Reset during STOP1: rst high for 1 cycle -> next cycle reel_run=000, all outputs 0, state IDLE; a new start begins a clean round.
- SPIN_EARLY_STOP_EN defined: start rise at SPIN cycle 3 -> reel 0 stops the next cycle. Undefined: the same stimulus has no effect.
